// File: rtl/motor_pkg.sv
// Shared encodings for the H-bridge motor controller.
package motor_pkg;

    localparam int unsigned CMD_W = 2;
    localparam int unsigned ST_W  = 3;

    localparam logic [CMD_W-1:0] CMD_COAST = 2'd0;
    localparam logic [CMD_W-1:0] CMD_FWD   = 2'd1;
    localparam logic [CMD_W-1:0] CMD_REV   = 2'd2;
    localparam logic [CMD_W-1:0] CMD_BRAKE = 2'd3;

    typedef enum logic [ST_W-1:0] {
        ST_COAST = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    // H-bridge pin pair, in1 in the MSB.
    typedef struct packed {
        logic in1;
        logic in2;
    } pins_t;

    localparam pins_t PINS_COAST = '{in1: 1'b0, in2: 1'b0};
    localparam pins_t PINS_BRAKE = '{in1: 1'b1, in2: 1'b1};

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to 0.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Metastability filter: first stage may go metastable, second is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/motor_hbridge_ctrl.sv
// H-bridge pin driver: PWM + direction/brake command to IN1/IN2 with
// reversal dead-time and a command-loss watchdog.
module motor_hbridge_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 50000,
    parameter int unsigned WDOG_CYCLES = 25000000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             in1,
    output logic             in2,
    output logic [ST_W-1:0]  state_o,
    output logic             wdog_trip
);

    localparam logic             WDOG_EN   = (WDOG_CYCLES != 0);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_MAX  = CNT_W'(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic             w_pwm_s;
    logic             w_accept;
    logic             w_wdog_fire;
    logic             w_load_dead;
    logic             w_ready_nxt;
    state_t           r_state;
    state_t           w_state_nxt;
    state_t           r_target;
    state_t           w_target_nxt;
    pins_t            r_pins;
    pins_t            w_pins_nxt;
    logic             r_ready;
    logic             r_trip;
    logic [CNT_W-1:0] r_dead_cnt;
    logic [CNT_W-1:0] r_wdog_cnt;

    sync_2ff #(.W(1)) u_pwm_sync (
        .clk   (clk_50MHz),
        .rst_n (rst_n),
        .i_d   (pwm_in),
        .o_q   (w_pwm_s)
    );

    assign w_accept    = cmd_valid && r_ready;
    // Commands win over an expiry landing on the same cycle.
    assign w_wdog_fire = WDOG_EN && !w_accept && (r_wdog_cnt >= WDOG_LAST) &&
                         ((r_state == ST_FWD) || (r_state == ST_REV));

    // State register with dead-time counter and latched post-dead target.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_COAST;
            r_target   <= ST_COAST;
            r_dead_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            if (w_load_dead) begin
                r_dead_cnt <= DEAD_LOAD;
            end else if ((r_state == ST_DEAD) && (r_dead_cnt != '0)) begin
                r_dead_cnt <= r_dead_cnt - CNT_W'(1);
            end
        end
    end

    // Next state: reversals and brake-to-drive go through DEAD.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_load_dead  = 1'b0;
        if (w_accept) begin
            case (cmd)
                CMD_COAST: w_state_nxt = ST_COAST;
                CMD_BRAKE: w_state_nxt = ST_BRAKE;
                CMD_FWD: begin
                    if ((r_state == ST_REV) || (r_state == ST_BRAKE)) begin
                        w_state_nxt  = ST_DEAD;
                        w_target_nxt = ST_FWD;
                        w_load_dead  = 1'b1;
                    end else begin
                        w_state_nxt = ST_FWD;
                    end
                end
                CMD_REV: begin
                    if ((r_state == ST_FWD) || (r_state == ST_BRAKE)) begin
                        w_state_nxt  = ST_DEAD;
                        w_target_nxt = ST_REV;
                        w_load_dead  = 1'b1;
                    end else begin
                        w_state_nxt = ST_REV;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end else if (w_wdog_fire) begin
            w_state_nxt = ST_COAST;
        end else if ((r_state == ST_DEAD) && (r_dead_cnt == '0)) begin
            w_state_nxt = r_target;
        end
    end

    // Output decode: pin pattern from current state, ready from next state.
    always_comb begin
        w_pins_nxt  = PINS_COAST;
        w_ready_nxt = (w_state_nxt != ST_DEAD);
        case (r_state)
            ST_FWD:   w_pins_nxt = '{in1: w_pwm_s, in2: 1'b0};
            ST_REV:   w_pins_nxt = '{in1: 1'b0, in2: w_pwm_s};
            ST_BRAKE: w_pins_nxt = PINS_BRAKE;
            default:  w_pins_nxt = PINS_COAST;
        endcase
    end

    // Output register for the bridge pins and the ready strobe.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pins  <= PINS_COAST;
            r_ready <= 1'b0;
        end else begin
            r_pins  <= w_pins_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Watchdog: saturating idle counter and sticky trip flag.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_trip     <= 1'b0;
        end else if (w_accept) begin
            r_wdog_cnt <= '0;
            r_trip     <= 1'b0;
        end else begin
            if (r_wdog_cnt != WDOG_MAX) begin
                r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
            end
            if (w_wdog_fire) begin
                r_trip <= 1'b1;
            end
        end
    end

    assign in1       = r_pins.in1;
    assign in2       = r_pins.in2;
    assign cmd_ready = r_ready;
    assign state_o   = r_state;
    assign wdog_trip = r_trip;

endmodule

// File: tb/tb_motor_hbridge_ctrl.sv
// Directed bench for motor_hbridge_ctrl with short dead-time and watchdog.
module tb_motor_hbridge_ctrl;

    localparam int unsigned DEAD = 4;
    localparam int unsigned WDOG = 20;
    localparam int unsigned CW   = 8;

    localparam logic [1:0] C_COAST = 2'd0;
    localparam logic [1:0] C_FWD   = 2'd1;
    localparam logic [1:0] C_REV   = 2'd2;
    localparam logic [1:0] C_BRAKE = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm_in;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       in1;
    logic       in2;
    logic [2:0] state_o;
    logic       wdog_trip;

    int   checks = 0;
    int   errors = 0;
    logic d1, d2, d3;
    bit   pwm_auto;
    int   pwm_cnt;

    motor_hbridge_ctrl #(
        .DEAD_CYCLES (DEAD),
        .WDOG_CYCLES (WDOG),
        .CNT_W       (CW)
    ) dut (
        .clk_50MHz (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .in1       (in1),
        .in2       (in2),
        .state_o   (state_o),
        .wdog_trip (wdog_trip)
    );

    always #5 clk = ~clk;

    // Advance one clock; d3 holds the pwm value the pins should show now.
    task automatic step();
        @(posedge clk);
        #1;
        d3 = d2;
        d2 = d1;
        d1 = pwm_in;
        if (pwm_auto) begin
            pwm_cnt++;
            pwm_in = ((pwm_cnt % 10) < 5);
        end
    endtask

    task automatic issue(input logic [1:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd = C_COAST; cmd_valid = 1'b0; pwm_in = 1'b0;
        pwm_auto = 1'b0; pwm_cnt = 0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        repeat (3) step();
        checks++; if ({in1, in2} !== 2'b00) begin errors++; $display("FAIL reset_pins: got %b expected 00", {in1, in2}); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_trip: got %b expected 0", wdog_trip); end
        rst_n = 1'b1;
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL first_clk_ready: got %b expected 1", cmd_ready); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL first_clk_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_fwd_pwm();
        pwm_auto = 1'b1;
        issue(C_FWD);
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL fwd_state: got %0d expected 1", state_o); end
        for (int i = 1; i <= 16; i++) begin
            if (i == 8) begin
                cmd = C_FWD; cmd_valid = 1'b1;
            end
            step();
            cmd_valid = 1'b0;
            checks++; if ({in1, in2} !== {d3, 1'b0}) begin errors++; $display("FAIL fwd_follow[%0d]: got %b expected %b", i, {in1, in2}, {d3, 1'b0}); end
            checks++; if (state_o !== 3'd1 || wdog_trip !== 1'b0) begin errors++; $display("FAIL fwd_hold[%0d]: got state %0d trip %b expected 1/0", i, state_o, wdog_trip); end
        end
    endtask

    task automatic test_reversal_dead();
        logic [2:0] exp_st;
        logic       exp_rdy;
        pwm_auto = 1'b0; pwm_in = 1'b1;
        issue(C_FWD);
        repeat (3) step();
        checks++; if ({in1, in2} !== 2'b10) begin errors++; $display("FAIL fwd_steady: got %b expected 10", {in1, in2}); end
        cmd = C_REV; cmd_valid = 1'b1;
        step();
        checks++; if (state_o !== 3'd4 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rev_enter_dead: got state %0d ready %b expected 4/0", state_o, cmd_ready); end
        checks++; if ({in1, in2} !== 2'b10) begin errors++; $display("FAIL rev_accept_pins: got %b expected 10", {in1, in2}); end
        cmd = C_BRAKE;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_st  = (i == 4) ? 3'd2 : 3'd4;
            exp_rdy = (i == 4);
            checks++; if ({in1, in2} !== 2'b00) begin errors++; $display("FAIL dead_pins[%0d]: got %b expected 00", i, {in1, in2}); end
            checks++; if (state_o !== exp_st) begin errors++; $display("FAIL dead_state[%0d]: got %0d expected %0d", i, state_o, exp_st); end
            checks++; if (cmd_ready !== exp_rdy) begin errors++; $display("FAIL dead_ready[%0d]: got %b expected %b", i, cmd_ready, exp_rdy); end
        end
        step();
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL held_cmd_accept: got %0d expected 3", state_o); end
        checks++; if ({in1, in2} !== 2'b01) begin errors++; $display("FAIL rev_pins: got %b expected 01", {in1, in2}); end
        cmd_valid = 1'b0;
        step();
        checks++; if ({in1, in2} !== 2'b11) begin errors++; $display("FAIL brake_pins: got %b expected 11", {in1, in2}); end
        issue(C_FWD);
        checks++; if (state_o !== 3'd4 || {in1, in2} !== 2'b11) begin errors++; $display("FAIL brake_to_dead: got state %0d pins %b expected 4/11", state_o, {in1, in2}); end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if ({in1, in2} !== 2'b00) begin errors++; $display("FAIL brake_dead_pins[%0d]: got %b expected 00", i, {in1, in2}); end
        end
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL brake_dead_exit: got %0d expected 1", state_o); end
        step();
        checks++; if ({in1, in2} !== 2'b10) begin errors++; $display("FAIL brake_fwd_pins: got %b expected 10", {in1, in2}); end
    endtask

    task automatic test_watchdog();
        issue(C_FWD);
        repeat (19) step();
        checks++; if (state_o !== 3'd1 || wdog_trip !== 1'b0) begin errors++; $display("FAIL wdog_early: got state %0d trip %b expected 1/0", state_o, wdog_trip); end
        step();
        checks++; if (state_o !== 3'd0 || wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_fire: got state %0d trip %b expected 0/1", state_o, wdog_trip); end
        step();
        checks++; if ({in1, in2} !== 2'b00) begin errors++; $display("FAIL wdog_pins: got %b expected 00", {in1, in2}); end
        repeat (5) step();
        checks++; if (wdog_trip !== 1'b1 || state_o !== 3'd0) begin errors++; $display("FAIL wdog_sticky: got trip %b state %0d expected 1/0", wdog_trip, state_o); end
        issue(C_FWD);
        checks++; if (wdog_trip !== 1'b0 || state_o !== 3'd1) begin errors++; $display("FAIL wdog_clear: got trip %b state %0d expected 0/1", wdog_trip, state_o); end
        step();
        checks++; if ({in1, in2} !== 2'b10) begin errors++; $display("FAIL wdog_resume: got %b expected 10", {in1, in2}); end
    endtask

    task automatic test_cmd_vs_wdog();
        issue(C_FWD);
        repeat (19) step();
        checks++; if (state_o !== 3'd1 || wdog_trip !== 1'b0) begin errors++; $display("FAIL race_pre: got state %0d trip %b expected 1/0", state_o, wdog_trip); end
        cmd = C_BRAKE; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++; if (state_o !== 3'd3 || wdog_trip !== 1'b0) begin errors++; $display("FAIL race_cmd_wins: got state %0d trip %b expected 3/0", state_o, wdog_trip); end
        step();
        checks++; if ({in1, in2} !== 2'b11 || wdog_trip !== 1'b0) begin errors++; $display("FAIL race_pins: got pins %b trip %b expected 11/0", {in1, in2}, wdog_trip); end
    endtask

    task automatic test_reset_mid_dead();
        issue(C_FWD);
        checks++; if (state_o !== 3'd4 || {in1, in2} !== 2'b11) begin errors++; $display("FAIL pre_rst_dead: got state %0d pins %b expected 4/11", state_o, {in1, in2}); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({in1, in2} !== 2'b00) begin errors++; $display("FAIL async_rst_pins: got %b expected 00", {in1, in2}); end
        checks++; if (state_o !== 3'd0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL async_rst_state: got state %0d ready %b expected 0/0", state_o, cmd_ready); end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        checks++; if (cmd_ready !== 1'b1 || state_o !== 3'd0) begin errors++; $display("FAIL post_rst: got ready %b state %0d expected 1/0", cmd_ready, state_o); end
        issue(C_REV);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL post_rst_rev: got %0d expected 2", state_o); end
        step();
        checks++; if ({in1, in2} !== 2'b01) begin errors++; $display("FAIL post_rst_pins: got %b expected 01", {in1, in2}); end
    endtask

    // Random traffic; opposite drives must be separated by DEAD cycles of 00
    // unless the controller deliberately coasted in between.
    task automatic test_random();
        logic [1:0]  pins;
        logic [1:0]  last_drive;
        logic [2:0]  prev_state;
        int unsigned zeros;
        pwm_auto   = 1'b1;
        last_drive = 2'b00;
        zeros      = 0;
        prev_state = state_o;
        for (int n = 0; n < 400; n++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd       = 2'($urandom_range(1, 3));
            step();
            pins = {in1, in2};
            if (pins == 2'b11) begin
                checks++; if (prev_state !== 3'd3) begin errors++; $display("FAIL rand_brake_only[%0d]: got prev state %0d expected 3", n, prev_state); end
                zeros = 0;
            end else if (pins == 2'b00) begin
                zeros++;
            end else begin
                if (last_drive != 2'b00 && last_drive != pins) begin
                    checks++; if (zeros < DEAD) begin errors++; $display("FAIL rand_dead_gap[%0d]: got %0d zero cycles expected >= %0d", n, zeros, DEAD); end
                end
                last_drive = pins;
                zeros      = 0;
            end
            checks++; if (state_o > 3'd4) begin errors++; $display("FAIL rand_state_enc[%0d]: got %0d expected <= 4", n, state_o); end
            if (state_o == 3'd0) last_drive = 2'b00;
            prev_state = state_o;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_pwm();
        test_reversal_dead();
        test_watchdog();
        test_cmd_vs_wdog();
        test_reset_mid_dead();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
